dcache_miss_ctrl: RTL and testbench
===================================

// Module: dcache_miss_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache with a miss-handling FSM.
//  Sits between the core's MEM stage and byte-lane main memory.
//  Hits complete combinationally with no stall.
//  Misses stall the pipeline while the FSM optionally writes back a dirty victim, then refills the line.
// PARAMETERS
//  IDX_W        3   index bits; LINES = 2**IDX_W one-word lines
//  MEM_LATENCY  4   cycles main memory needs per access (>=1)
// PORTS
//  clk             in   1     clock, rising edge
//  rst_b           in   1     asynchronous active-low reset
//  req_valid       in   1     MEM-stage access request
//  req_we          in   1     1 = store, 0 = load
//  req_is_word     in   1     1 = word access, 0 = byte access
//  req_addr        in   32    byte address
//  req_wdata       in   4x8   store data; byte store uses lane [0]
//  rdata           out  4x8   addressed line, lane k = byte (addr&~3)+k
//  cache_hit       out  1     valid && tag match for req_addr
//  cache_dirty     out  1     dirty bit of indexed line
//  stall           out  1     freeze IF..MEM; request must be held stable
//  mem_addr        out  32    word-aligned main-memory address
//  mem_data_in     out  4x8   victim data to memory
//  mem_data_out    in   4x8   memory read data
//  mem_write_en    out  1     memory write strobe
// BEHAVIOUR
//  Address split: idx = req_addr[IDX_W+1:2]; tag = req_addr[31:IDX_W+2]; addr[1:0] = byte lane.
//  Reset (async, rst_b=0):
//   - all valid/dirty bits = 0; state = IDLE; counter = 0
//   - stall = 0, mem_write_en = 0, mem_addr = 0, mem_data_in = 0, rdata = 0
//   - any in-flight writeback/refill is abandoned; memory write stops immediately
//  Data array contents are not reset.
//  States: IDLE, WB, FILL.
//  IDLE:
//   - hit load: rdata = line; no stall.
//   - hit store: at clk edge, write word (or lane addr[1:0] <- wdata[0]) and set dirty; no stall.
//   - miss with victim valid&dirty: stall=1, go to WB.
//   - miss otherwise: stall=1, go to FILL.
//   - req_valid=0: nothing happens.
//  WB:
//   - mem_addr = {victim_tag, idx, 2'b00}; mem_data_in = victim data.
//   - mem_write_en = 1 for exactly MEM_LATENCY cycles.
//   - Then clear dirty and go to FILL.
//  FILL:
//   - mem_addr = {tag, idx, 2'b00}; mem_write_en = 0.
//   - On the MEM_LATENCY-th cycle, capture mem_data_out into the line, set valid, clear dirty, go to IDLE.
//  Back in IDLE the held request now hits and completes (store sets dirty); stall drops that cycle.
//  stall = (state != IDLE) | (req_valid & ~cache_hit).
//  Miss penalty, measured from miss cycle to hit cycle:
//   - MEM_LATENCY+1 cycles clean
//   - 2*MEM_LATENCY+1 cycles dirty
//  Counter counts 0..MEM_LATENCY-1 and resets on every state change.
//  mem_addr holds its last value in IDLE; mem_write_en is 0 outside WB.
//  Requests arriving or changing while stall=1 are a protocol violation; the FSM ignores them until IDLE.
//  Byte load returns the whole line; the WB stage selects the lane.
//  Same-index different-tag accesses always evict; there is no associativity.
// TESTING
//  1. Reset, then load 0x0000_0010 (L=4): stall high 5 cycles, no write strobe; after that hit, rdata = mem word.
//  2. Store word 0xDEADBEEF to 0x10 (hit): no stall; next load 0x10 returns EF,BE,AD,DE per lane order; dirty=1.
//  3. Load 0x30 (same idx=4, other tag) after 2: mem_write_en high 4 cycles @0x10 with stored data, then 4 FILL cycles @0x30; stall 9.
//  4. Byte store 0x5A to 0x13 (hit): only lane 3 changes; other lanes unchanged.
//  5. Assert rst_b=0 in the 2nd WB cycle: mem_write_en and stall drop asynchronously; after release, load 0x10 misses.
//  6. Back-to-back hits to 8 distinct indices after fill: zero stall cycles; MEM_LATENCY=1 regression also passes.

Source files
------------

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped write-back, write-allocate data cache with one-word lines.
// A miss stalls the core while an IDLE/WB/FILL FSM evicts a dirty victim and refills the line.
module dcache_miss_ctrl #(
  parameter int IDX_W       = 3,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_is_word,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        cache_hit,
  output logic        cache_dirty,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_write_en
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic [31:0]        mem_addr_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               last_cnt;
  logic               wr_hit;
  logic               fill_done;
  logic [31:0]        line_d;

  assign idx         = req_addr[IDX_W+1:2];
  assign tag         = req_addr[31:IDX_W+2];
  assign cache_hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign cache_dirty = dirty_q[idx];
  // Invalid lines read as zero so nothing from the unreset data array leaks out.
  assign rdata       = valid_q[idx] ? data_q[idx] : '0;
  assign last_cnt    = (cnt_q == CNT_W'(MEM_LATENCY - 1));
  assign stall       = rst_b & ((state_q != IDLE) | (req_valid & ~cache_hit));

  always_comb begin
    line_d = data_q[idx];
    if (req_is_word) begin
      line_d = req_wdata;
    end else begin
      line_d[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    wr_hit       = 1'b0;
    fill_done    = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = mem_addr_q;
    mem_data_in  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (cache_hit) begin
            if (req_we) begin
              wr_hit       = 1'b1;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
            cnt_d   = '0;
          end
        end
      end
      WB: begin
        mem_addr     = {tag_q[idx], idx, 2'b00};
        mem_data_in  = data_q[idx];
        mem_write_en = 1'b1;
        if (last_cnt) begin
          dirty_d[idx] = 1'b0;
          state_d      = FILL;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FILL: begin
        mem_addr = {tag, idx, 2'b00};
        if (last_cnt) begin
          fill_done    = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      mem_addr_q <= mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_q[idx] <= line_d;
    end else if (fill_done) begin
      data_q[idx] <= mem_data_out;
      tag_q[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: a MEM_LATENCY=4 instance with a writable memory
// model and a MEM_LATENCY=1 instance for the short-latency regression.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        sel = 1'b0;
  logic        req_v = 1'b0, req_we = 1'b0, req_word = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic        rv0, rv1;
  logic [31:0] rdata0, rdata1, maddr0, maddr1, mdin0, mdin1, mdout0, mdout1;
  logic        hit0, hit1, dirty0, dirty1, stall0, stall1, mwe0, mwe1;

  logic        stall_s, mwe_s, hit_s, dirty_s;
  logic [31:0] rdata_s, maddr_s, mdin_s;

  int checks = 0;
  int failures = 0;
  int ns, nwe, total;
  logic [31:0] wb_addr, wb_data, fill_addr, expw;

  always #5 clk = ~clk;

  assign rv0 = req_v & ~sel;
  assign rv1 = req_v & sel;

  dcache_miss_ctrl #(.IDX_W(3), .MEM_LATENCY(4)) dut0 (
    .clk(clk), .rst_b(rst_b), .req_valid(rv0), .req_we(req_we), .req_is_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata0), .cache_hit(hit0),
    .cache_dirty(dirty0), .stall(stall0), .mem_addr(maddr0), .mem_data_in(mdin0),
    .mem_data_out(mdout0), .mem_write_en(mwe0));

  dcache_miss_ctrl #(.IDX_W(3), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .req_valid(rv1), .req_we(req_we), .req_is_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata1), .cache_hit(hit1),
    .cache_dirty(dirty1), .stall(stall1), .mem_addr(maddr1), .mem_data_in(mdin1),
    .mem_data_out(mdout1), .mem_write_en(mwe1));

  assign stall_s = sel ? stall1 : stall0;
  assign mwe_s   = sel ? mwe1   : mwe0;
  assign hit_s   = sel ? hit1   : hit0;
  assign dirty_s = sel ? dirty1 : dirty0;
  assign rdata_s = sel ? rdata1 : rdata0;
  assign maddr_s = sel ? maddr1 : maddr0;
  assign mdin_s  = sel ? mdin1  : mdin0;

  // Background memory content: every word encodes its own address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA0B0_C000 | a;
  endfunction

  bit          inited = 1'b0;
  logic [31:0] mem0 [64];
  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 64; i++) mem0[i] <= memf(32'(i * 4));
      inited <= 1'b1;
    end else if (mwe0) begin
      mem0[maddr0[7:2]] <= mdin0;
    end
  end
  assign mdout0 = mem0[maddr0[7:2]];
  assign mdout1 = memf(maddr1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until it hits; leaves the bench in the settled hit cycle.
  task automatic access(input logic we, input logic word, input logic [31:0] addr,
                        input logic [31:0] wd, output int n_stall, output int n_we);
    req_v = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wd;
    n_stall = 0; n_we = 0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (!stall_s) break;
      n_stall++;
      if (mwe_s) begin
        n_we++;
        wb_addr = maddr_s;
        wb_data = mdin_s;
      end
      fill_addr = maddr_s;
      @(posedge clk); #1;
    end
    if (stall_s) check("access_timeout", 32'(stall_s), 32'd0);
  endtask

  task automatic retire();
    @(posedge clk); #1;
    req_v = 1'b0;
  endtask

  initial begin
    #1 rst_b = 1'b0;
    #2;
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_mwe", 32'(mwe0), 32'd0);
    check("rst_maddr", maddr0, 32'd0);
    check("rst_mdin", mdin0, 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    #19 rst_b = 1'b1;
    @(posedge clk); #1;

    // 1: clean load miss
    access(1'b0, 1'b1, 32'h10, 32'h0, ns, nwe);
    check("t1_stall_cycles", 32'(ns), 32'd5);
    check("t1_no_wstrobe", 32'(nwe), 32'd0);
    check("t1_fill_addr", fill_addr, 32'h10);
    check("t1_hit", 32'(hit0), 32'd1);
    check("t1_rdata", rdata0, memf(32'h10));
    retire();

    // 2: word store hit, then load back
    access(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, ns, nwe);
    check("t2_store_stall", 32'(ns), 32'd0);
    retire();
    access(1'b0, 1'b1, 32'h10, 32'h0, ns, nwe);
    check("t2_rdata", rdata0, 32'hDEADBEEF);
    check("t2_lane0", 32'(rdata0[7:0]), 32'hEF);
    check("t2_lane3", 32'(rdata0[31:24]), 32'hDE);
    check("t2_dirty", 32'(dirty0), 32'd1);
    retire();

    // 4: byte store to lane 3
    access(1'b1, 1'b0, 32'h13, 32'h0000_005A, ns, nwe);
    check("t4_store_stall", 32'(ns), 32'd0);
    retire();
    access(1'b0, 1'b1, 32'h10, 32'h0, ns, nwe);
    check("t4_rdata", rdata0, 32'h5AADBEEF);
    retire();

    // 3: conflicting load evicts the dirty line
    access(1'b0, 1'b1, 32'h30, 32'h0, ns, nwe);
    check("t3_stall_cycles", 32'(ns), 32'd9);
    check("t3_wstrobe_cycles", 32'(nwe), 32'd4);
    check("t3_wb_addr", wb_addr, 32'h10);
    check("t3_wb_data", wb_data, 32'h5AADBEEF);
    check("t3_fill_addr", fill_addr, 32'h30);
    check("t3_rdata", rdata0, memf(32'h30));
    check("t3_dirty", 32'(dirty0), 32'd0);
    check("t3_mem_written", mem0[4], 32'h5AADBEEF);
    retire();

    // 5: reset during the second writeback cycle
    access(1'b1, 1'b1, 32'h30, 32'h12345678, ns, nwe);
    retire();
    req_v = 1'b1; req_we = 1'b0; req_word = 1'b1; req_addr = 32'h10;
    #2;
    check("t5_miss_stall", 32'(stall0), 32'd1);
    @(posedge clk); #3;
    check("t5_wb1_mwe", 32'(mwe0), 32'd1);
    check("t5_wb1_addr", maddr0, 32'h30);
    @(posedge clk); #1;
    check("t5_wb2_mwe", 32'(mwe0), 32'd1);
    rst_b = 1'b0;
    #1;
    check("t5_rst_mwe", 32'(mwe0), 32'd0);
    check("t5_rst_stall", 32'(stall0), 32'd0);
    check("t5_rst_maddr", maddr0, 32'd0);
    req_v = 1'b0;
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
    req_v = 1'b1;
    #1;
    check("t5_post_hit", 32'(hit0), 32'd0);
    access(1'b0, 1'b1, 32'h10, 32'h0, ns, nwe);
    check("t5_post_stall", 32'(ns), 32'd5);
    check("t5_post_rdata", rdata0, 32'h5AADBEEF);
    retire();

    // 6: fill all indices, then back-to-back hits
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b1, 32'(i * 4), 32'h0, ns, nwe);
      check("t6_fill_stall", 32'(ns), (i == 4) ? 32'd0 : 32'd5);
      retire();
    end
    total = 0;
    req_v = 1'b1; req_we = 1'b0; req_word = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'(i * 4);
      #2;
      if (stall0) total++;
      expw = (i == 4) ? 32'h5AADBEEF : memf(32'(i * 4));
      check("t6_b2b_rdata", rdata0, expw);
      @(posedge clk); #1;
    end
    req_v = 1'b0;
    check("t6_b2b_stalls", 32'(total), 32'd0);

    // MEM_LATENCY=1 regression
    sel = 1'b1;
    access(1'b0, 1'b1, 32'h04, 32'h0, ns, nwe);
    check("l1_clean_stall", 32'(ns), 32'd2);
    check("l1_clean_rdata", rdata1, memf(32'h04));
    retire();
    access(1'b1, 1'b1, 32'h04, 32'h11111111, ns, nwe);
    check("l1_store_stall", 32'(ns), 32'd0);
    retire();
    access(1'b0, 1'b1, 32'h24, 32'h0, ns, nwe);
    check("l1_dirty_stall", 32'(ns), 32'd3);
    check("l1_wstrobe", 32'(nwe), 32'd1);
    check("l1_wb_addr", wb_addr, 32'h04);
    check("l1_wb_data", wb_data, 32'h11111111);
    check("l1_rdata", rdata1, memf(32'h24));
    retire();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
